// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a ready/valid output buffer.
// Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module uart_rx #(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       rdata_ready,
  output logic       ferr,
  output logic       overrun
);
  localparam logic [31:0] HALF = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] FULL = 32'(2 * CLK_PER_HALF_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_sync;
  logic        r_rxd_s;
  logic        w_stop_tick;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_wr;
  assign w_stop_tick = (r_state == STOP) && (r_cnt == FULL);
  assign w_push      = w_stop_tick & r_rxd_s;
  assign w_pop       = rdata_valid & rdata_ready;
  assign w_wr        = w_push & (~w_full | w_pop);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync  <= 1'b1;
      r_rxd_s <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      ferr    <= 1'b0;
    end else begin
      r_sync  <= rxd;
      r_rxd_s <= r_sync;
      ferr    <= w_stop_tick & ~r_rxd_s;
      case (r_state)
        IDLE: if (!r_rxd_s) begin
          r_state <= START;
          r_cnt   <= '0;
        end
        START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= r_rxd_s ? IDLE : DATA;
        end else r_cnt <= r_cnt + 32'd1;
        DATA: if (r_cnt == FULL) begin
          r_cnt          <= '0;
          r_shift[r_idx] <= r_rxd_s;
          r_idx          <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 32'd1;
        STOP: if (r_cnt == FULL) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 32'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef UART_RX_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_wp;
  logic [1:0] r_rp;
  logic [2:0] r_level;
  assign w_full      = r_level == 3'd4;
  assign rdata       = r_mem[r_rp];
  assign rdata_valid = r_level != 3'd0;
  // When full, a simultaneous pop and push share the head slot: rp moves on as it is rewritten.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mem   <= '{default: '0};
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= w_push & ~w_wr;
      if (w_wr) begin
        r_mem[r_wp] <= r_shift;
        r_wp        <= r_wp + 2'd1;
      end
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_level <= r_level + 3'(w_wr) - 3'(w_pop);
    end
  end
`else
  logic [7:0] r_data;
  logic       r_valid;
  assign w_full      = r_valid;
  assign rdata       = r_data;
  assign rdata_valid = r_valid;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= w_push & ~w_wr;
      if (w_wr) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) r_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus corner sequences; a queue scoreboard checks every consumed byte.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int H     = 4;
  localparam int BIT   = 2 * H;
  localparam int FRAME = 10 * BIT;
  localparam int LAT   = 79;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       rdata_ready = 1'b0;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       ferr;
  logic       overrun;
  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .rdata(rdata), .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready), .ferr(ferr), .overrun(overrun)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, c0 = 0, rise = -1, ferr_n = 0, ovr_n = 0;
  logic [7:0] q[$];
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [7:0] pd = '0;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;
  vec_t tbl[8];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask
  // Scoreboard monitor: handshakes pop expected bytes; a stalled byte must not change.
  always @(negedge clk) begin
    if (rstn && prst && pv && !pr) begin
      chk("hold_valid", 32'(rdata_valid), 32'd1);
      chk("hold_data", 32'(rdata), 32'(pd));
    end
    if (rdata_valid && !pv) rise = cyc;
    if (ferr === 1'b1) ferr_n++;
    if (overrun === 1'b1) ovr_n++;
    if (rdata_valid && rdata_ready) begin
      if (q.size() == 0) chk("unexpected_byte", 32'(rdata), 32'h100);
      else chk("pop_data", 32'(rdata), 32'(q.pop_front()));
    end
    pv = rdata_valid;
    pr = rdata_ready;
    pd = rdata;
    prst = rstn;
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int ready_at, input int rst_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    c0 = cyc;
    for (int k = 0; k < FRAME; k++) begin
      rxd = fr[k / BIT];
      if (ready_at >= 0 && k == ready_at) rdata_ready = 1'b1;
      if (ready_at >= 0 && k == ready_at + 1) rdata_ready = 1'b0;
      if (rst_at >= 0 && k == rst_at) rstn = 1'b0;
      if (rst_at >= 0 && k == rst_at + 3) rstn = 1'b1;
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("midrst_rdata", 32'(rdata), 32'd0);
        chk("midrst_valid", 32'(rdata_valid), 32'd0);
        chk("midrst_ferr", 32'(ferr), 32'd0);
        chk("midrst_overrun", 32'(overrun), 32'd0);
      end
      idle(1);
    end
    rxd = 1'b1;
  endtask
  initial begin
    int f0, o0;
    tbl[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h55, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h7E, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    idle(3);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_valid", 32'(rdata_valid), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    idle(5);
    rdata_ready = 1'b1;
    f0 = ferr_n;
    rise = -1;
    q.push_back(8'h29);
    send(8'h29, 1'b1, -1, -1);
    idle(4);
    chk("lat_29", 32'(rise - c0), 32'(LAT));
    chk("ferr_29", 32'(ferr_n - f0), 32'd0);
    foreach (tbl[i]) begin
      f0 = ferr_n;
      rise = -1;
      if (tbl[i].exp_valid) q.push_back(tbl[i].d);
      send(tbl[i].d, tbl[i].stop, -1, -1);
      idle(4);
      chk("tbl_ferr", 32'(ferr_n - f0), 32'(tbl[i].exp_ferr));
      chk("tbl_valid_cycle", 32'(rise - c0), tbl[i].exp_valid ? 32'(LAT) : 32'(-1 - c0));
    end
    f0 = ferr_n;
    rise = -1;
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(20);
    chk("glitch_valid", 32'(rise), 32'(-1));
    chk("glitch_ferr", 32'(ferr_n - f0), 32'd0);
    f0 = ferr_n;
    rxd = 1'b0;
    idle(FRAME);
    rxd = 1'b1;
    idle(20);
    chk("break_ferr", 32'(ferr_n - f0), 32'd1);
    chk("break_valid", 32'(rise), 32'(-1));
    q.push_back(8'hC6);
    send(8'hC6, 1'b1, -1, -1);
    idle(4);
    chk("post_break_valid", 32'(rise - c0), 32'(LAT));
    rdata_ready = 1'b0;
    o0 = ovr_n;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) q.push_back(8'(i));
      send(8'(i), 1'b1, -1, -1);
    end
    idle(4);
    chk("ovr_count", 32'(ovr_n - o0), 32'(5 - DEPTH));
    chk("ovr_head", 32'(rdata), 32'h01);
    chk("ovr_valid", 32'(rdata_valid), 32'd1);
    rdata_ready = 1'b1;
    idle(10);
    chk("ovr_drained", 32'(q.size()), 32'd0);
    rdata_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      q.push_back(8'(8'h10 + i));
      send(8'(8'h10 + i), 1'b1, -1, -1);
    end
    o0 = ovr_n;
    q.push_back(8'h99);
    send(8'h99, 1'b1, LAT - 1, -1);
    idle(4);
    chk("swap_overrun", 32'(ovr_n - o0), 32'd0);
    chk("swap_valid", 32'(rdata_valid), 32'd1);
    chk("swap_pending", 32'(q.size()), 32'(DEPTH));
    rdata_ready = 1'b1;
    idle(10);
    chk("swap_drained", 32'(q.size()), 32'd0);
    rdata_ready = 1'b0;
    send(8'h5A, 1'b1, -1, -1);
    idle(2);
    send(8'hFF, 1'b1, -1, 4 * BIT + 4);
    idle(4);
    chk("after_rst_valid", 32'(rdata_valid), 32'd0);
    q.push_back(8'hC3);
    send(8'hC3, 1'b1, -1, -1);
    idle(4);
    chk("after_rst_data", 32'(rdata), 32'hC3);
    chk("after_rst_valid2", 32'(rdata_valid), 32'd1);
    rdata_ready = 1'b1;
    idle(4);
    chk("after_rst_single", 32'(rdata_valid), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_PER_HALF_BIT, default 5208, sets the clk cycles per half UART bit; one bit period is 2*CLK_PER_HALF_BIT cycles.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 rxd  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 rdata  output  8  received byte at the head of the output buffer.
REQ-006 rdata_valid  output  1  high while rdata holds an unconsumed byte.
REQ-007 rdata_ready  input  1  consumer accepts rdata in any cycle where rdata_valid and rdata_ready are both high.
REQ-008 ferr  output  1  one-cycle pulse on a framing error (stop bit sampled low).
REQ-009 overrun  output  1  one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxd_s), adding 2 cycles of input latency.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; a 32-bit cycle counter and a 3-bit bit index support them.
REQ-012 IDLE: on rxd_s==0, go to START with counter=0.
REQ-013 START: at counter==CLK_PER_HALF_BIT-1, sample rxd_s; if 0, go to DATA with counter=0 and index=0; if 1 (glitch), return to IDLE without any output.
REQ-014 DATA: at counter==2*CLK_PER_HALF_BIT-1, shift rxd_s into bit[index] (LSB first), counter=0; after index 7, go to STOP.
REQ-015 STOP: at counter==2*CLK_PER_HALF_BIT-1, sample rxd_s, then return to IDLE in the same cycle (mid-stop resynchronization).
REQ-016 On a stop sample of 1, the byte SHALL be pushed to the output buffer; on 0, the byte is discarded and ferr pulses in the following cycle.
REQ-017 A pushed byte SHALL appear with rdata_valid=1 in the cycle after the stop-bit sample.
REQ-018 rdata and rdata_valid SHALL remain stable until the handshake completes.
REQ-019 A push into a full buffer SHALL drop the new byte, keep the buffered contents, and pulse overrun.
REQ-020 When full, a pop and a push in the same cycle SHALL both take effect: the pop frees a slot and the push is accepted with no overrun.
REQ-021 A continuous low rxd (break) SHALL yield byte 0x00 with ferr, then repeat START detection; no lockup.

Reset
REQ-022 With rstn=0 at a clk edge: FSM=IDLE, counter=0, index=0, shift register=0, buffer empty, rdata=0, rdata_valid=0, ferr=0, overrun=0, synchronizer flops=1.
REQ-023 A reset asserted mid-frame SHALL abandon the frame; the remainder of the line is treated as fresh input after release.

Configuration
REQ-024 Macro UART_RX_FIFO_EN: when defined, the output buffer SHALL be a 4-entry FIFO.
  - rdata = head entry; rdata_valid = not empty.
  - full means 4 entries.
REQ-025 Without UART_RX_FIFO_EN, the output buffer SHALL be a single holding register; full means rdata_valid=1.

Verification
REQ-026 CLK_PER_HALF_BIT=4; send 0x29 as 8N1 (bit period 8 clk) -> rdata=0x29 and rdata_valid=1 exactly 1 cycle after the stop sample; ferr=0.
REQ-027 Pulse rxd low for 2 cycles only -> START aborts to IDLE; rdata_valid stays 0.
REQ-028 Send 0x55 with the stop bit forced low -> ferr pulses 1 cycle; rdata_valid stays 0; a following 0xA5 is received correctly.
REQ-029 rdata_ready=0; send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back -> with FIFO: 0x01..0x04 retained, overrun pulses on 0x05; without FIFO: 0x01 retained, overrun pulses on each later byte.
REQ-030 Assert rstn=0 during DATA bit 3 of a frame, then release and send 0xC3 -> all outputs at reset values during reset; afterwards rdata=0xC3 only.
REQ-031 Full buffer with rdata_ready=1 in the exact push cycle -> no overrun; byte count is unchanged and the order is preserved.
